// File: rtl/alarm_tone_pkg.sv
// Shared constants, types and the note-pattern ROM for the alarm tone sequencer.
package alarm_tone_pkg;

  localparam logic [3:0] NOTE_SIL = 4'd0;
  localparam logic [3:0] NOTE_C2  = 4'd8;
  localparam logic [3:0] NOTE_E2  = 4'd10;
  localparam logic [3:0] NOTE_G2  = 4'd12;
  localparam logic [3:0] NOTE_A2  = 4'd13;
  localparam logic [3:0] NOTE_C3  = 4'd15;

  localparam logic [1:0] ID_FLOOD = 2'd0;
  localparam logic [1:0] ID_GAS   = 2'd1;
  localparam logic [1:0] ID_CHIME = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_DONE,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [3:0] note;
    logic [3:0] dur;
  } step_t;

  localparam step_t [0:2][0:3] PATTERN_ROM = '{
    '{'{NOTE_C3, 4'd4}, '{NOTE_SIL, 4'd2}, '{NOTE_C3, 4'd4}, '{NOTE_SIL, 4'd2}},
    '{'{NOTE_A2, 4'd3}, '{NOTE_E2,  4'd3}, '{NOTE_A2, 4'd3}, '{NOTE_E2,  4'd3}},
    '{'{NOTE_G2, 4'd6}, '{NOTE_C2, 4'd10}, '{NOTE_SIL, 4'd0}, '{NOTE_SIL, 4'd0}}
  };

  // Out-of-range requester or step index reads as an end-of-pattern step.
  function automatic step_t rom_step(input logic [1:0] id, input logic [2:0] s);
    if (id == ID_NONE || s[2]) return '0;
    return PATTERN_ROM[id][s[1:0]];
  endfunction

  function automatic logic [1:0] first_set(input logic [2:0] pend);
    if (pend[0]) return ID_FLOOD;
    if (pend[1]) return ID_GAS;
    if (pend[2]) return ID_CHIME;
    return ID_NONE;
  endfunction

  function automatic logic [2:0] higher_prio_mask(input logic [1:0] id);
    case (id)
      ID_FLOOD: return 3'b000;
      ID_GAS:   return 3'b001;
      ID_CHIME: return 3'b011;
      default:  return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/tone_tick_gen.sv
// Base-tick prescaler plus duration-unit counter; expire_o marks the last cycle of dur_i units.
module tone_tick_gen #(
  parameter int TICK_DIV   = 100000,
  parameter int UNIT_TICKS = 50
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       clr_i,
  input  logic [3:0] dur_i,
  output logic       expire_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int UW = $clog2(UNIT_TICKS * 15);

  logic [TW-1:0] tick_q, tick_d;
  logic [UW-1:0] unit_q, unit_d;
  logic          tick_last;
  logic [UW-1:0] unit_tgt;

  always_comb begin
    tick_last = (tick_q == TW'(TICK_DIV - 1));
    unit_tgt  = UW'(32'(dur_i) * UNIT_TICKS - 1);
    expire_o  = tick_last && (unit_q == unit_tgt);
    tick_d    = tick_q;
    unit_d    = unit_q;
    if (clr_i) begin
      tick_d = '0;
      unit_d = '0;
    end else if (tick_last) begin
      tick_d = '0;
      unit_d = UW'(unit_q + 1'b1);
    end else begin
      tick_d = TW'(tick_q + 1'b1);
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
    end
  end

endmodule

// File: rtl/alarm_tone_sequencer.sv
// Fixed-priority alarm arbiter and note-pattern player for the PWM tone generator.
// Optional mute input is enabled by defining ALARM_TONE_MUTE_EN.
module alarm_tone_sequencer
  import alarm_tone_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int UNIT_TICKS = 50,
  parameter int GAP_UNITS  = 4
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic [2:0] req,
`ifdef ALARM_TONE_MUTE_EN
  input  logic       mute,
`endif
  output logic [3:0] note,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done
);

  state_t     state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [1:0] active_q, active_d;
  logic [2:0] step_q, step_d;
  logic [3:0] note_q, note_d;
  logic [2:0] clr_pend;
  logic [1:0] preempt_id;
  logic       tick_clr;
  logic       expire;
  logic [3:0] dur_sel;
  step_t      cur;

  tone_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .UNIT_TICKS(UNIT_TICKS)
  ) u_tick (
    .clk_fpga(clk_fpga),
    .reset   (reset),
    .clr_i   (tick_clr),
    .dur_i   (dur_sel),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    step_d     = step_q;
    note_d     = note_q;
    clr_pend   = '0;
    cur        = rom_step(active_q, step_q);
    preempt_id = first_set(pending_q & higher_prio_mask(active_q));
    dur_sel    = (state_q == ST_GAP) ? 4'(GAP_UNITS) : cur.dur;
    unique case (state_q)
      ST_IDLE: begin
        note_d = NOTE_SIL;
        if (pending_q != '0) begin
          active_d = first_set(pending_q);
          step_d   = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (step_q[2] || cur.dur == '0) begin
          note_d  = NOTE_SIL;
          state_d = ST_DONE;
        end else begin
          note_d  = cur.note;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (expire) begin
          state_d = ST_LOAD;
          if (preempt_id != ID_NONE) begin
            active_d = preempt_id;
            step_d   = '0;
          end else begin
            step_d = 3'(step_q + 3'd1);
          end
        end
      end
      ST_DONE: begin
        clr_pend = 3'b001 << active_q;
        note_d   = NOTE_SIL;
        state_d  = ST_GAP;
      end
      ST_GAP: begin
        if (expire) begin
          active_d = ID_NONE;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The LOAD cycle is the first counted cycle of a step, so each note lasts exactly dur units.
    tick_clr  = (state_d == ST_LOAD) || (state_q == ST_DONE);
    pending_d = (pending_q & ~clr_pend) | req;
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      active_q  <= ID_NONE;
      step_q    <= '0;
      note_q    <= NOTE_SIL;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      step_q    <= step_d;
      note_q    <= note_d;
    end
  end

`ifdef ALARM_TONE_MUTE_EN
  assign note = mute ? NOTE_SIL : note_q;
`else
  assign note = note_q;
`endif
  assign busy      = (state_q != ST_IDLE);
  assign active_id = active_q;
  assign done      = (state_q == ST_DONE);

endmodule
